lag_tile_sink: RTL and testbench



---
 rtl/lag_tile_sink_pkg.sv | 36 +++
 rtl/lag_sink_fifo.sv | 59 +++++
 rtl/lag_tile_sink.sv | 142 ++++++++++++++
 tb/tb_lag_tile_sink.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_tile_sink_pkg.sv
// Shared LAG mesh types for the tile sink: flit layout, entry parameters and
// the sink's sticky error bit indices.
package lag_tile_sink_pkg;

  localparam int unsigned FLIT_ID_W = 8;
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned HOPS_W    = 8;
  localparam int unsigned DATA_W    = 16;

  localparam int unsigned router_num_pls_on_entry = 1;

  // Sticky error vector layout of lag_tile_sink.err
  localparam int unsigned SINK_ERR_OVF  = 0;
  localparam int unsigned SINK_ERR_SEQ  = 1;
  localparam int unsigned SINK_ERR_DEST = 2;
  localparam int unsigned SINK_ERR_W    = 3;

  typedef struct packed {
    logic valid;
    logic tail;
  } flit_control_t;

  typedef struct packed {
    logic [FLIT_ID_W-1:0] flit_id;
    logic [COORD_W-1:0]   xdest;
    logic [COORD_W-1:0]   ydest;
    logic [HOPS_W-1:0]    hops;
  } flit_debug_t;

  typedef struct packed {
    flit_control_t       control;
    flit_debug_t         debug;
    logic [DATA_W-1:0]   data;
  } flit_t;

endpackage

// File: rtl/lag_sink_fifo.sv
// Per-link flit buffer for the tile sink.
// Ports: clk, rst (sync, active-high), push_i/data_i write side,
//        pop_i read side, full_o/empty_o status, head_o oldest flit.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module lag_sink_fifo
  import lag_tile_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  flit_t data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output flit_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  flit_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/lag_tile_sink.sv
// Ejection-side consumer of one mesh tile port.
// Buffers each link, drains one flit per cycle round-robin, returns a credit
// per drained flit, checks sequence/destination and keeps statistics.
// Ports: clk, rst (sync, active-high), flit_in per-link flits, stall tile
//        backpressure, cntrl_out credits, flit_out/flit_out_link drained
//        flit, flits_rcvd/pkts_rcvd/hop_sum counters, err sticky errors.
module lag_tile_sink
  import lag_tile_sink_pkg::*;
#(
  parameter  int unsigned global_links_num = 2,
  parameter  int unsigned BUF_DEPTH        = 4,
  parameter  int unsigned X_ID             = 0,
  parameter  int unsigned Y_ID             = 0,
  parameter  int unsigned CNT_W            = 32,
  localparam int unsigned LINK_W = (global_links_num > 1) ? $clog2(global_links_num) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  flit_t [global_links_num-1:0]        flit_in,
  input  logic                                stall,
  output logic  [global_links_num-1:0]        cntrl_out,
  output flit_t                               flit_out,
  output logic  [LINK_W-1:0]                  flit_out_link,
  output logic  [CNT_W-1:0]                   flits_rcvd,
  output logic  [CNT_W-1:0]                   pkts_rcvd,
  output logic  [CNT_W-1:0]                   hop_sum,
  output logic  [SINK_ERR_W-1:0]              err
);

  logic [global_links_num-1:0] push;
  logic [global_links_num-1:0] pop;
  logic [global_links_num-1:0] full;
  logic [global_links_num-1:0] empty;
  flit_t                       heads [global_links_num];

  logic [LINK_W-1:0]           rr_q;
  logic [FLIT_ID_W-1:0]        exp_q [global_links_num];
  logic [global_links_num-1:0] cntrl_q;
  flit_t                       flit_q;
  logic [LINK_W-1:0]           link_q;
  logic [CNT_W-1:0]            flits_q;
  logic [CNT_W-1:0]            pkts_q;
  logic [CNT_W-1:0]            hop_q;
  logic [SINK_ERR_W-1:0]       err_q;

  logic                        win_valid;
  logic [LINK_W-1:0]           win_idx;
  logic [LINK_W-1:0]           scan_link;
  logic [LINK_W-1:0]           rr_next;
  flit_t                       head_sel;
  logic                        seq_bad;
  logic                        dest_bad;
  logic                        ovf;

  for (genvar c = 0; c < global_links_num; c++) begin : g_link
    assign push[c] = flit_in[c].control.valid;
    assign pop[c]  = win_valid && (win_idx == LINK_W'(c));

    lag_sink_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[c]),
      .data_i  (flit_in[c]),
      .pop_i   (pop[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .head_o  (heads[c])
    );
  end

  // Round-robin: first non-empty link at or after the pointer, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_link = '0;
    if (!stall) begin
      for (int unsigned i = 0; i < global_links_num; i++) begin
        scan_link = LINK_W'((32'(rr_q) + i) % global_links_num);
        if (!win_valid && !empty[scan_link]) begin
          win_valid = 1'b1;
          win_idx   = scan_link;
        end
      end
    end
  end

  assign rr_next  = (win_idx == LINK_W'(global_links_num - 1)) ? '0 : win_idx + LINK_W'(1);
  assign head_sel = heads[win_idx];
  assign seq_bad  = (head_sel.debug.flit_id != exp_q[win_idx]);
  assign dest_bad = (head_sel.debug.xdest != COORD_W'(X_ID)) ||
                    (head_sel.debug.ydest != COORD_W'(Y_ID));
  // A popping link frees its slot in the same cycle, so only pop-less full links overflow.
  assign ovf      = |(push & full & ~pop);

  // Drain, credit, checks and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      cntrl_q <= '0;
      flit_q  <= '0;
      link_q  <= '0;
      flits_q <= '0;
      pkts_q  <= '0;
      hop_q   <= '0;
      err_q   <= '0;
      for (int unsigned c = 0; c < global_links_num; c++) begin
        exp_q[c] <= FLIT_ID_W'(1);
      end
    end else begin
      cntrl_q <= '0;
      flit_q  <= '0;
      link_q  <= '0;
      if (win_valid) begin
        flit_q           <= head_sel;
        link_q           <= win_idx;
        cntrl_q[win_idx] <= 1'b1;
        rr_q             <= rr_next;
        exp_q[win_idx]   <= head_sel.control.tail ? FLIT_ID_W'(1)
                                                  : exp_q[win_idx] + FLIT_ID_W'(1);
        flits_q          <= flits_q + CNT_W'(1);
        if (head_sel.control.tail) begin
          pkts_q <= pkts_q + CNT_W'(1);
        end
        if (head_sel.debug.flit_id == FLIT_ID_W'(1)) begin
          hop_q <= hop_q + CNT_W'(head_sel.debug.hops);
        end
        if (seq_bad)  err_q[SINK_ERR_SEQ]  <= 1'b1;
        if (dest_bad) err_q[SINK_ERR_DEST] <= 1'b1;
      end
      if (ovf) err_q[SINK_ERR_OVF] <= 1'b1;
    end
  end

  assign cntrl_out     = cntrl_q;
  assign flit_out      = flit_q;
  assign flit_out_link = link_q;
  assign flits_rcvd    = flits_q;
  assign pkts_rcvd     = pkts_q;
  assign hop_sum       = hop_q;
  assign err           = err_q;

endmodule

// File: tb/tb_lag_tile_sink.sv
// Self-checking bench for lag_tile_sink: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_lag_tile_sink;
  import lag_tile_sink_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned XI    = 1;
  localparam int unsigned YI    = 2;
  localparam int unsigned CW    = 32;

  logic               clk = 1'b0;
  logic               rst;
  flit_t [N-1:0]      flit_in;
  logic               stall;
  logic [N-1:0]       cntrl_out;
  flit_t              flit_out;
  logic [0:0]         flit_out_link;
  logic [CW-1:0]      flits_rcvd, pkts_rcvd, hop_sum;
  logic [2:0]         err;

  always #5 clk = ~clk;

  lag_tile_sink #(
    .global_links_num(N), .BUF_DEPTH(DEPTH), .X_ID(XI), .Y_ID(YI), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .stall(stall),
    .cntrl_out(cntrl_out), .flit_out(flit_out), .flit_out_link(flit_out_link),
    .flits_rcvd(flits_rcvd), .pkts_rcvd(pkts_rcvd), .hop_sum(hop_sum), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int credit_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue per link, applied pop-then-push each edge.
  flit_t          mq [N][$];
  int             m_rr;
  logic [7:0]     m_exp [N];
  logic [CW-1:0]  m_flits, m_pkts, m_hop;
  logic [2:0]     m_err;
  flit_t          e_flit;
  int             e_link;
  logic [N-1:0]   e_cntrl;

  task automatic model_step(input flit_t [N-1:0] fin, input logic st, input logic r);
    int win;
    flit_t f;
    if (r) begin
      for (int c = 0; c < N; c++) begin mq[c].delete(); m_exp[c] = 8'd1; end
      m_rr = 0; m_flits = '0; m_pkts = '0; m_hop = '0; m_err = '0;
      e_flit = '0; e_link = 0; e_cntrl = '0;
      return;
    end
    win = -1;
    if (!st) begin
      for (int i = 0; i < N; i++) begin
        if (win < 0 && mq[(m_rr + i) % N].size() > 0) win = (m_rr + i) % N;
      end
    end
    e_flit = '0; e_link = 0; e_cntrl = '0;
    if (win >= 0) begin
      f = mq[win].pop_front();
      e_flit = f; e_link = win; e_cntrl[win] = 1'b1;
      if (f.debug.flit_id != m_exp[win]) m_err[1] = 1'b1;
      m_exp[win] = f.control.tail ? 8'd1 : m_exp[win] + 8'd1;
      if (f.debug.xdest != 4'(XI) || f.debug.ydest != 4'(YI)) m_err[2] = 1'b1;
      m_flits += 1;
      if (f.control.tail) m_pkts += 1;
      if (f.debug.flit_id == 8'd1) m_hop += CW'(f.debug.hops);
      m_rr = (win + 1) % N;
    end
    for (int c = 0; c < N; c++) begin
      if (fin[c].control.valid) begin
        if (mq[c].size() >= DEPTH) m_err[0] = 1'b1;
        else mq[c].push_back(fin[c]);
      end
    end
  endtask

  task automatic cycle();
    model_step(flit_in, stall, rst);
    @(posedge clk);
    #1;
    check("flit_out",  64'(flit_out),      64'(e_flit));
    check("link",      64'(flit_out_link), 64'(e_link));
    check("cntrl_out", 64'(cntrl_out),     64'(e_cntrl));
    check("flits",     64'(flits_rcvd),    64'(m_flits));
    check("pkts",      64'(pkts_rcvd),     64'(m_pkts));
    check("hop_sum",   64'(hop_sum),       64'(m_hop));
    check("err",       64'(err),           64'(m_err));
    credit_cnt += $countones(cntrl_out);
  endtask

  // Well-formed packet generator per link
  logic [7:0] g_id [N];
  int         g_left [N];

  task automatic gen_reset();
    for (int c = 0; c < N; c++) begin g_id[c] = 8'd1; g_left[c] = 0; end
  endtask

  function automatic flit_t mkf(input int id, input logic tail, input int x, input int y, input int hops);
    flit_t f;
    f = '0;
    f.control.valid = 1'b1;
    f.control.tail  = tail;
    f.debug.flit_id = 8'(id);
    f.debug.xdest   = 4'(x);
    f.debug.ydest   = 4'(y);
    f.debug.hops    = 8'(hops);
    f.data          = 16'($urandom);
    return f;
  endfunction

  task automatic gen_flit(input int c, input int len, output flit_t f);
    logic tl;
    if (g_left[c] == 0) g_left[c] = len;
    tl = (g_left[c] == 1);
    f = mkf(int'(g_id[c]), tl, XI, YI, int'($urandom_range(0, 15)));
    g_left[c]--;
    g_id[c] = tl ? 8'd1 : g_id[c] + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flit_in = '0;
    cycle();
    rst = 1'b0;
    gen_reset();
  endtask

  flit_t      f;
  logic [7:0] e_ids [3];

  initial begin
    rst = 1'b1; stall = 1'b0; flit_in = '0;
    gen_reset();
    cycle();
    cycle();
    check("rst_valid", 64'(flit_out.control.valid), 64'(0));
    check("rst_err",   64'(err),                    64'(0));
    rst = 1'b0;

    // Single-flit packet on link 0
    flit_in[0] = mkf(1, 1'b1, XI, YI, 3);
    cycle();
    flit_in = '0;
    check("single_lat0", 64'(flit_out.control.valid), 64'(0));
    cycle();
    check("single_valid", 64'(flit_out.control.valid), 64'(1));
    check("single_cntrl", 64'(cntrl_out),  64'(2'b01));
    check("single_flits", 64'(flits_rcvd), 64'(1));
    check("single_pkts",  64'(pkts_rcvd),  64'(1));
    check("single_hops",  64'(hop_sum),    64'(3));
    check("single_err",   64'(err),        64'(0));
    cycle();
    check("single_cntrl_off", 64'(cntrl_out), 64'(0));

    // Both links busy: two bursts of 4-flit packets
    do_reset();
    credit_cnt = 0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < N; c++) begin gen_flit(c, 4, f); flit_in[c] = f; end
        cycle();
      end
      flit_in = '0;
      repeat (6) cycle();
    end
    check("dual_credits", 64'(credit_cnt), 64'(16));
    check("dual_err",     64'(err),        64'(0));

    // Stalled tile: fill link 1, overflow, then release
    do_reset();
    stall = 1'b1;
    credit_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      gen_flit(1, 4, f); flit_in[1] = f;
      cycle();
    end
    check("stall_credits", 64'(credit_cnt), 64'(0));
    check("stall_noovf",   64'(err),        64'(0));
    gen_flit(1, 1, f); flit_in[1] = f;
    cycle();
    flit_in = '0;
    check("stall_ovf", 64'(err), 64'(3'b001));
    stall = 1'b0;
    repeat (8) cycle();
    check("stall_drained", 64'(credit_cnt), 64'(4));
    check("stall_flits",   64'(flits_rcvd), 64'(4));

    // Sequence gap on link 0 (1,2,4), link 1 well-formed
    do_reset();
    e_ids[0] = 8'd1; e_ids[1] = 8'd2; e_ids[2] = 8'd4;
    for (int k = 0; k < 3; k++) begin
      flit_in[0] = mkf(int'(e_ids[k]), 1'b0, XI, YI, k);
      gen_flit(1, 2, f); flit_in[1] = f;
      cycle();
    end
    flit_in = '0;
    repeat (6) cycle();
    check("seq_err", 64'(err), 64'(3'b010));

    // Wrong destination still delivered
    do_reset();
    flit_in[0] = mkf(1, 1'b1, XI + 1, YI, 2);
    cycle();
    flit_in = '0;
    cycle();
    check("dest_valid", 64'(flit_out.control.valid), 64'(1));
    check("dest_cntrl", 64'(cntrl_out), 64'(2'b01));
    check("dest_err",   64'(err),       64'(3'b100));

    // Reset with flits buffered discards them
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin gen_flit(0, 4, f); flit_in[0] = f; cycle(); end
    flit_in = '0;
    rst = 1'b1;
    credit_cnt = 0;
    cycle();
    rst = 1'b0; stall = 1'b0;
    gen_reset();
    check("mrst_flits", 64'(flits_rcvd), 64'(0));
    check("mrst_cntrl", 64'(cntrl_out),  64'(0));
    cycle();
    check("mrst_nocredit", 64'(credit_cnt), 64'(0));
    flit_in[0] = mkf(1, 1'b1, XI, YI, 5);
    cycle();
    flit_in = '0;
    cycle();
    check("mrst_new_flits", 64'(flits_rcvd), 64'(1));
    check("mrst_new_hops",  64'(hop_sum),    64'(5));
    check("mrst_new_err",   64'(err),        64'(0));

    // Random traffic with occasional stall, corruption and one mid-run reset
    do_reset();
    for (int n = 0; n < 500; n++) begin
      stall = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          gen_flit(c, int'($urandom_range(1, 4)), f);
          if ($urandom_range(0, 63) == 0) f.debug.flit_id = f.debug.flit_id ^ 8'h05;
          if ($urandom_range(0, 63) == 0) f.debug.ydest   = f.debug.ydest ^ 4'h1;
          flit_in[c] = f;
        end else begin
          flit_in[c] = '0;
        end
      end
      if (n == 250) begin rst = 1'b1; flit_in = '0; end
      cycle();
      if (n == 250) begin rst = 1'b0; gen_reset(); end
    end
    flit_in = '0; stall = 1'b0;
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
